// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state encoding, hit record type and fine-code encoder for
// the multi-hit TDC. Build option: TDC_BUBBLE_FIX_EN selects the popcount
// encoder; without it the encoder counts leading ones from tap 0.
package tdc_pkg;

  // Configuration that the hit record is sized from. The top-level parameters
  // default to these values and must agree with them.
  localparam int TDC_NUM_CH    = 4;
  localparam int TDC_COARSE_W  = 16;
  localparam int TDC_FINE_TAPS = 32;
  localparam int TDC_FINE_W    = $clog2(TDC_FINE_TAPS) + 1;
  localparam int TDC_CH_W      = (TDC_NUM_CH > 1) ? $clog2(TDC_NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  typedef struct packed {
    logic [TDC_CH_W-1:0]     ch;
    logic [TDC_COARSE_W-1:0] coarse;
    logic [TDC_FINE_W-1:0]   fine;
  } hit_t;

  // Thermometer snapshot -> fine code in the range 0..FINE_TAPS.
  function automatic logic [TDC_FINE_W-1:0] enc(input logic [TDC_FINE_TAPS-1:0] therm);
    logic [TDC_FINE_W-1:0] code;
`ifndef TDC_BUBBLE_FIX_EN
    logic run;
`endif
    code = '0;
`ifdef TDC_BUBBLE_FIX_EN
    for (int i = 0; i < TDC_FINE_TAPS; i++) begin
      code = code + TDC_FINE_W'(therm[i]);
    end
`else
    run = 1'b1;
    for (int i = 0; i < TDC_FINE_TAPS; i++) begin
      run  = run & therm[i];
      code = code + TDC_FINE_W'(run);
    end
`endif
    return code;
  endfunction

endpackage

// File: rtl/tdc_result_fifo.sv
// tdc_result_fifo: synchronous FIFO of hit records. Head is presented while
// non-empty and reads as zero when empty; a push at full succeeds only if a
// pop happens in the same cycle.
module tdc_result_fifo
  import tdc_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  hit_t             push_data,
  input  logic             pop,
  output hit_t             head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  hit_t             mem_reg [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointers and exact occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = empty ? '0 : mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/tdc_sync.sv
// tdc_sync: multi-stage flop synchronizer for asynchronous pins.
module tdc_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  // Shift the pin values through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/tdc_multihit.sv
// tdc_multihit: one start pin opens a window; each stop channel records one
// hit {channel, coarse, fine} per window into a result FIFO.
// Build option: TDC_BUBBLE_FIX_EN (fine encoder variant, see tdc_pkg).
module tdc_multihit
  import tdc_pkg::*;
#(
  parameter  int NUM_CH      = TDC_NUM_CH,
  parameter  int COARSE_W    = TDC_COARSE_W,
  parameter  int FINE_TAPS   = TDC_FINE_TAPS,
  parameter  int FINE_W      = $clog2(FINE_TAPS) + 1,
  parameter  int FIFO_DEPTH  = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arm,
  input  logic                        continuous,
  input  logic [COARSE_W-1:0]         timeout,
  input  logic                        clr_flags,
  input  logic                        start_in,
  input  logic [NUM_CH-1:0]           stop_in,
  input  logic [NUM_CH*FINE_TAPS-1:0] fine_therm,
  output logic                        busy,
  output logic [NUM_CH-1:0]           hit_mask,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [CH_W-1:0]             rd_ch,
  output logic [COARSE_W-1:0]         rd_coarse,
  output logic [FINE_W-1:0]           rd_fine,
  output logic [CNT_W-1:0]            fifo_count,
  output logic                        overflow,
  output logic                        timed_out
);

  state_t              state_reg, state_next;
  logic [COARSE_W-1:0] coarse_reg;
  logic [NUM_CH-1:0]   hit_mask_reg;
  logic [NUM_CH-1:0]   pend_valid_reg;
  hit_t                pend_data_reg [NUM_CH];
  logic                overflow_reg, timed_out_reg;

  logic [NUM_CH:0]     pin_sync, pin_prev_reg, pin_edge;
  logic                start_edge;
  logic [NUM_CH-1:0]   stop_edge, capture, grant;
  logic [FINE_W-1:0]   fine_code [NUM_CH];
  logic                all_hit, timeout_exit;
  logic                push, pop, drop, fifo_full, fifo_empty;
  hit_t                push_data, head;

  tdc_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (NUM_CH + 1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({stop_in, start_in}),
    .q   (pin_sync)
  );

  // Previous synchronized level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) pin_prev_reg <= '0;
    else     pin_prev_reg <= pin_sync;
  end

  assign pin_edge   = pin_sync & ~pin_prev_reg;
  assign start_edge = pin_edge[0];
  assign stop_edge  = pin_edge[NUM_CH:1];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign fine_code[gi] = enc(fine_therm[gi*FINE_TAPS +: FINE_TAPS]);
      assign capture[gi]   = (state_reg == RUN) && stop_edge[gi] && !hit_mask_reg[gi];
    end
  endgenerate

  assign all_hit = &(hit_mask_reg | capture);

  // Fixed-priority drain: lowest occupied pending slot goes to the FIFO.
  always_comb begin
    grant     = '0;
    push_data = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_valid_reg[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        push_data = pend_data_reg[i];
      end
    end
  end

  assign push = |pend_valid_reg;
  assign pop  = rd_valid && rd_ready;
  assign drop = push && fifo_full && !pop;

  tdc_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; an all-hit exit takes precedence over a timeout.
  always_comb begin
    state_next   = state_reg;
    timeout_exit = 1'b0;
    case (state_reg)
      IDLE:  if (arm) state_next = ARMED;
      ARMED: if (start_edge) state_next = RUN;
      RUN: begin
        if (all_hit) begin
          state_next = DONE;
        end else if (coarse_reg == timeout) begin
          state_next   = DONE;
          timeout_exit = 1'b1;
        end
      end
      DONE:  if (pend_valid_reg == '0) state_next = continuous ? ARMED : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Coarse counter, hit mask, pending slots and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      coarse_reg     <= '0;
      hit_mask_reg   <= '0;
      pend_valid_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) pend_data_reg[i] <= '0;
      overflow_reg   <= 1'b0;
      timed_out_reg  <= 1'b0;
    end else begin
      // The start detect cycle counts as 0, so the following cycle reads 1.
      if (state_reg == ARMED && start_edge) begin
        coarse_reg   <= COARSE_W'(1);
        hit_mask_reg <= '0;
      end else if (state_reg == RUN) begin
        if (coarse_reg != '1) coarse_reg <= coarse_reg + COARSE_W'(1);
        hit_mask_reg <= hit_mask_reg | capture;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture[i]) begin
          pend_valid_reg[i] <= 1'b1;
          pend_data_reg[i]  <= '{ch: CH_W'(i), coarse: coarse_reg, fine: fine_code[i]};
        end else if (grant[i]) begin
          pend_valid_reg[i] <= 1'b0;
        end
      end
      if (drop)              overflow_reg <= 1'b1;
      else if (clr_flags)    overflow_reg <= 1'b0;
      if (timeout_exit)      timed_out_reg <= 1'b1;
      else if (clr_flags)    timed_out_reg <= 1'b0;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign hit_mask  = hit_mask_reg;
  assign rd_valid  = !fifo_empty;
  assign rd_ch     = head.ch;
  assign rd_coarse = head.coarse;
  assign rd_fine   = head.fine;
  assign overflow  = overflow_reg;
  assign timed_out = timed_out_reg;

endmodule

// File: tb/tb_tdc_multihit.sv
// tb_tdc_multihit: table-driven windows plus hand sequences for overflow,
// flag clearing and reset mid-window.
module tb_tdc_multihit;
  import tdc_pkg::*;

  localparam int SYNC = 2;
`ifdef TDC_BUBBLE_FIX_EN
  localparam int F7E = 7;
`else
  localparam int F7E = 3;
`endif

  logic         clk = 0;
  logic         rst, arm, continuous, clr_flags, start_in, rd_ready;
  logic [15:0]  timeout;
  logic [3:0]   stop_in;
  logic [127:0] fine_therm;
  logic         busy, rd_valid, overflow, timed_out;
  logic [3:0]   hit_mask;
  logic [1:0]   rd_ch;
  logic [15:0]  rd_coarse;
  logic [5:0]   rd_fine;
  logic [3:0]   fifo_count;

  tdc_multihit dut (
    .clk (clk), .rst (rst), .arm (arm), .continuous (continuous),
    .timeout (timeout), .clr_flags (clr_flags), .start_in (start_in),
    .stop_in (stop_in), .fine_therm (fine_therm), .busy (busy),
    .hit_mask (hit_mask), .rd_valid (rd_valid), .rd_ready (rd_ready),
    .rd_ch (rd_ch), .rd_coarse (rd_coarse), .rd_fine (rd_fine),
    .fifo_count (fifo_count), .overflow (overflow), .timed_out (timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          dly[4];
    logic [31:0] therm[4];
    bit          rep1;
    int          tmo;
    int          len;
    int          n_exp;
    logic [23:0] exp_e[4];
    logic        tmo_exp;
    logic [3:0]  mask_exp;
  } row_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [23:0] got_q[$];
  int          got_cyc[$];
  row_t rows[6];
  row_t ov;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every head that is accepted at the next edge.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      got_q.push_back({rd_ch, rd_coarse, rd_fine});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [23:0] mk(input int ch, input int co, input int fi);
    return {2'(ch), 16'(co), 6'(fi)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  // Raise start, then each stop pin at its delay (in cycles after start).
  task automatic run_window(input row_t r);
    for (int c = 0; c < 4; c++) fine_therm[c*32 +: 32] = r.therm[c];
    timeout  = 16'(r.tmo);
    start_in = 1'b1;
    for (int k = 1; k <= r.len; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (r.dly[c] == k) stop_in[c] = 1'b1;
      if (r.rep1 && k == r.dly[1] + 3) stop_in[1] = 1'b0;
      if (r.rep1 && k == r.dly[1] + 6) stop_in[1] = 1'b1;
    end
    start_in = 1'b0;
    stop_in  = '0;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  task automatic pulse_clr_arm();
    @(negedge clk) clr_flags = 1'b1;
    @(negedge clk) begin clr_flags = 1'b0; arm = 1'b1; end
    @(negedge clk) arm = 1'b0;
  endtask

  task automatic do_row(input row_t r, input string tag);
    int n;
    got_q.delete();
    got_cyc.delete();
    pulse_clr_arm();
    run_window(r);
    n = 0;
    while ((busy || rd_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_count"}, 32'(fifo_count), 0);
    chk({tag, "_entries"}, got_q.size(), r.n_exp);
    for (int i = 0; i < r.n_exp; i++)
      chk($sformatf("%s_e%0d", tag, i), (i < got_q.size()) ? got_q[i] : 24'hFFFFFF, r.exp_e[i]);
    chk({tag, "_timed_out"}, 32'(timed_out), 32'(r.tmo_exp));
    chk({tag, "_hit_mask"}, 32'(hit_mask), 32'(r.mask_exp));
  endtask

  task automatic chk_rest(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_timed_out"}, 32'(timed_out), 0);
    chk({tag, "_hit_mask"}, 32'(hit_mask), 0);
    chk({tag, "_head"}, {rd_ch, rd_coarse, rd_fine}, 0);
  endtask

  initial begin
    // Single shot, times out because channels 1..3 never hit.
    rows[0].dly = '{10, 0, 0, 0};   rows[0].therm = '{32'hFF, 0, 0, 0};
    rows[0].rep1 = 0; rows[0].tmo = 40; rows[0].len = 60; rows[0].n_exp = 1;
    rows[0].exp_e = '{mk(0, 10, 8), 0, 0, 0}; rows[0].tmo_exp = 1; rows[0].mask_exp = 4'h1;
    // All channels at distinct times; fine-code extremes.
    rows[1].dly = '{3, 7, 12, 5};   rows[1].therm = '{32'hFF, 32'hF7, 32'hFFFF_FFFF, 0};
    rows[1].rep1 = 0; rows[1].tmo = 100; rows[1].len = 40; rows[1].n_exp = 4;
    rows[1].exp_e = '{mk(0, 3, 8), mk(3, 5, 0), mk(1, 7, F7E), mk(2, 12, 32)};
    rows[1].tmo_exp = 0; rows[1].mask_exp = 4'hF;
    // ch1 and ch2 simultaneous; ch1 gets a repeat edge that must be ignored.
    rows[2].dly = '{9, 5, 5, 15};   rows[2].therm = '{32'h1, 32'h3, 32'h7, 32'hF};
    rows[2].rep1 = 1; rows[2].tmo = 100; rows[2].len = 40; rows[2].n_exp = 4;
    rows[2].exp_e = '{mk(1, 5, 2), mk(2, 5, 3), mk(0, 9, 1), mk(3, 15, 4)};
    rows[2].tmo_exp = 0; rows[2].mask_exp = 4'hF;
    // Timeout 20, only ch0 hits, bubbled snapshot.
    rows[3].dly = '{4, 0, 0, 0};    rows[3].therm = '{32'hF7, 0, 0, 0};
    rows[3].rep1 = 0; rows[3].tmo = 20; rows[3].len = 40; rows[3].n_exp = 1;
    rows[3].exp_e = '{mk(0, 4, F7E), 0, 0, 0}; rows[3].tmo_exp = 1; rows[3].mask_exp = 4'h1;
    // Last hit lands exactly at the timeout count: all-hit exit wins.
    rows[4].dly = '{2, 3, 4, 8};    rows[4].therm = '{32'hFF, 32'hFF, 32'hFF, 32'hFF};
    rows[4].rep1 = 0; rows[4].tmo = 8; rows[4].len = 30; rows[4].n_exp = 4;
    rows[4].exp_e = '{mk(0, 2, 8), mk(1, 3, 8), mk(2, 4, 8), mk(3, 8, 8)};
    rows[4].tmo_exp = 0; rows[4].mask_exp = 4'hF;
    // A non-final hit at the timeout count is still captured.
    rows[5].dly = '{6, 0, 0, 0};    rows[5].therm = '{0, 0, 0, 0};
    rows[5].rep1 = 0; rows[5].tmo = 6; rows[5].len = 30; rows[5].n_exp = 1;
    rows[5].exp_e = '{mk(0, 6, 0), 0, 0, 0}; rows[5].tmo_exp = 1; rows[5].mask_exp = 4'h1;

    rst = 1; arm = 0; continuous = 0; clr_flags = 0; start_in = 0; rd_ready = 0;
    timeout = 0; stop_in = 0; fine_therm = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_rest("reset");

    rd_ready = 1;
    for (int r = 0; r < 6; r++) begin
      do_row(rows[r], $sformatf("row%0d", r));
      if (r == 2)
        chk("row2_consecutive", (got_cyc.size() >= 2) ? got_cyc[1] - got_cyc[0] : -1, 1);
    end

    // Sticky timeout flag clears on a clr_flags pulse.
    chk("tmo_before_clr", 32'(timed_out), 1);
    @(negedge clk) clr_flags = 1;
    @(negedge clk) clr_flags = 0;
    chk("tmo_after_clr", 32'(timed_out), 0);

    // Overflow: three continuous windows of four hits with the reader stalled.
    rd_ready = 0; continuous = 1;
    ov.dly = '{2, 4, 6, 8}; ov.rep1 = 0; ov.tmo = 100; ov.len = 20; ov.n_exp = 0;
    ov.exp_e = '{0, 0, 0, 0}; ov.tmo_exp = 0; ov.mask_exp = 0;
    pulse_clr_arm();
    ov.therm = '{32'h1, 32'h1, 32'h1, 32'h1};
    run_window(ov);
    ov.therm = '{32'h3, 32'h3, 32'h3, 32'h3};
    run_window(ov);
    chk("ovf_count_full", 32'(fifo_count), 8);
    chk("ovf_not_yet", 32'(overflow), 0);
    ov.therm = '{32'h7, 32'h7, 32'h7, 32'h7};
    run_window(ov);
    chk("ovf_count_held", 32'(fifo_count), 8);
    chk("ovf_set", 32'(overflow), 1);
    got_q.delete();
    got_cyc.delete();
    rd_ready = 1;
    repeat (12) @(negedge clk);
    chk("ovf_popped", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("ovf_e%0d", i), (i < got_q.size()) ? got_q[i] : 24'hFFFFFF,
          mk(i % 4, 2 + 2 * (i % 4), 1 + i / 4));
    chk("ovf_drained", 32'(fifo_count), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // Reset in the middle of a window with an entry waiting in the FIFO.
    continuous = 0; rd_ready = 0;
    ov.dly = '{3, 0, 0, 0}; ov.therm = '{32'hFF, 0, 0, 0}; ov.len = 10;
    run_window(ov);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_count", 32'(fifo_count), 1);
    @(negedge clk) rst = 1;
    @(negedge clk);
    chk_rest("mid_rst");
    rst = 0;
    rd_ready = 1;
    do_row(rows[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
